ic_refill_ctrl: RTL and testbench

IC_REFILL_CTRL -- requirements
Module: ic_refill_ctrl

---
 rtl/ic_refill_ctrl.sv | 143 ++++++++++++++
 tb/tb_ic_refill_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ic_refill_ctrl.sv
// Instruction-cache refill controller: fetches one block from memory into a
// local buffer, then streams it word by word to the cache under a grant.
module ic_refill_ctrl #(
  parameter int unsigned B = 64,
  parameter int unsigned W = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          ic_miss_i,
  input  logic [31:0]   miss_addr_i,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o,
  input  logic          mem_ack_i,
  input  logic          mem_rvalid_i,
  input  logic [W-1:0]  mem_rdata_i,
  output logic          ic_repl_grant_o,
  output logic [W-1:0]  rep_word_o,
  output logic          refill_done_o,
  output logic          busy_o
);

  localparam int unsigned BEATS = (B * 8) / W;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [31:0]   BLK_MASK  = ~32'(B - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  beat, beat_nxt;
  logic [31:0]    addr, addr_nxt;
  logic           buf_we;
  logic [W-1:0]   buffer [BEATS];

  logic           req_nxt;
  logic [31:0]    mem_addr_nxt;
  logic           grant_nxt;
  logic [W-1:0]   word_nxt;
  logic           done_nxt;
  logic           busy_nxt;

  // Next state, beat/address bookkeeping and next-cycle output values
  always_comb begin
    state_nxt    = state;
    beat_nxt     = beat;
    addr_nxt     = addr;
    buf_we       = 1'b0;
    req_nxt      = 1'b0;
    mem_addr_nxt = '0;
    grant_nxt    = 1'b0;
    word_nxt     = '0;
    done_nxt     = 1'b0;
    busy_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (ic_miss_i) begin
          addr_nxt  = miss_addr_i & BLK_MASK;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          beat_nxt  = '0;
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (mem_rvalid_i) begin
          buf_we = 1'b1;
          if (beat == LAST_BEAT) begin
            beat_nxt  = '0;
            state_nxt = STREAM;
          end else begin
            beat_nxt = beat + BW'(1);
          end
        end
      end
      STREAM: begin
        if (beat == LAST_BEAT) begin
          beat_nxt  = '0;
          state_nxt = DONE;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    req_nxt      = (state_nxt == REQ);
    mem_addr_nxt = req_nxt ? addr_nxt : '0;
    grant_nxt    = (state_nxt == STREAM);
    done_nxt     = (state_nxt == DONE);
    busy_nxt     = (state_nxt != IDLE);
    // Single-beat blocks stream the word being written this very cycle
    if (grant_nxt) begin
      word_nxt = (buf_we && (beat == beat_nxt)) ? mem_rdata_i : buffer[beat_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state           <= IDLE;
      beat            <= '0;
      addr            <= '0;
      mem_req_o       <= 1'b0;
      mem_addr_o      <= '0;
      ic_repl_grant_o <= 1'b0;
      rep_word_o      <= '0;
      refill_done_o   <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state           <= state_nxt;
      beat            <= beat_nxt;
      addr            <= addr_nxt;
      mem_req_o       <= req_nxt;
      mem_addr_o      <= mem_addr_nxt;
      ic_repl_grant_o <= grant_nxt;
      rep_word_o      <= word_nxt;
      refill_done_o   <= done_nxt;
      busy_o          <= busy_nxt;
    end
  end

  // Block buffer holds no reset; every entry is rewritten before it is streamed
  always_ff @(posedge clk_i) begin
    if (buf_we) begin
      buffer[beat] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Randomized scoreboard bench for ic_refill_ctrl: a driver acts as CPU and
// memory and queues expected responses; a monitor checks what the DUT presents.
module tb_ic_refill_ctrl;

  localparam int unsigned B     = 64;
  localparam int unsigned W     = 64;
  localparam int unsigned BEATS = (B * 8) / W;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          ic_miss_i = 1'b0;
  logic [31:0]   miss_addr_i = '0;
  logic          mem_req_o;
  logic [31:0]   mem_addr_o;
  logic          mem_ack_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [W-1:0]  mem_rdata_i = '0;
  logic          ic_repl_grant_o;
  logic [W-1:0]  rep_word_o;
  logic          refill_done_o;
  logic          busy_o;

  int errors = 0;
  int checks = 0;

  logic [31:0]  exp_addr[$];
  logic [W-1:0] exp_words[$];
  bit           exp_done[$];

  ic_refill_ctrl #(.B(B), .W(W)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .ic_miss_i       (ic_miss_i),
    .miss_addr_i     (miss_addr_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .ic_repl_grant_o (ic_repl_grant_o),
    .rep_word_o      (rep_word_o),
    .refill_done_o   (refill_done_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every presented response against the scoreboard queues
  int  run_len  = 0;
  int  last_run = 0;
  bit  prev_grant = 1'b0;
  bit  prev_done  = 1'b0;

  always @(negedge clk) begin
    if (mem_req_o) begin
      if (exp_addr.size() == 0) fail("unexpected_mem_req");
      else begin
        check("mem_addr", 64'(mem_addr_o), 64'(exp_addr[0]));
        if (mem_ack_i) void'(exp_addr.pop_front());
      end
    end
    if (ic_repl_grant_o) begin
      run_len++;
      if (exp_words.size() == 0) fail("unexpected_grant");
      else check("rep_word", 64'(rep_word_o), 64'(exp_words.pop_front()));
    end else begin
      if (prev_grant) last_run = run_len;
      run_len = 0;
      if (rep_word_o !== '0) check("rep_word_idle", 64'(rep_word_o), 64'd0);
    end
    if (prev_done) check("done_one_cycle", {62'd0, refill_done_o, busy_o}, 64'd0);
    if (refill_done_o) begin
      check("done_grant_low", 64'(ic_repl_grant_o), 64'd0);
      if (exp_done.size() == 0) fail("unexpected_done");
      else begin
        void'(exp_done.pop_front());
        check("stream_len", 64'(last_run), 64'(BEATS));
      end
    end
    prev_grant = ic_repl_grant_o;
    prev_done  = refill_done_o;
  end

  // Driver: one complete refill; the reference model is simply "the block at
  // the aligned address comes back in arrival order, once, then one done".
  task automatic refill(input logic [31:0] a, input int ack_dly, input bit gapped,
                        input bit spurious, input bit hold, input logic [31:0] new_addr,
                        input int rst_beat, input bit seq_data);
    int n;
    int g;
    logic [W-1:0] d;
    exp_addr.push_back(a & ~32'(B - 1));
    miss_addr_i = a;
    ic_miss_i   = 1'b1;
    if (spurious) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = W'(64'hDEAD);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_req_o && n < 50);
    if (!mem_req_o) begin
      fail("timeout_mem_req");
      ic_miss_i = 1'b0;
      return;
    end
    if (!hold) ic_miss_i = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      step();
      check("req_held", 64'(mem_req_o), 64'd1);
    end
    mem_ack_i = 1'b1;
    step();
    mem_ack_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (gapped) begin
        n = (b % 3 == 1) ? 2 : ((b % 3 == 2) ? 1 : 0);
        if ($urandom_range(0, 3) == 0) n = n + 1;
        for (int k = 0; k < n; k++) begin
          mem_rdata_i = W'({$urandom, $urandom});
          step();
        end
      end
      d = seq_data ? W'(64'h0123_4567_89AB_CD00 + 64'(b)) : W'({$urandom, $urandom});
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = d;
      exp_words.push_back(d);
      if (hold && b == 4) miss_addr_i = new_addr;
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = W'(64'hDEAD);
    end
    if (rst_beat < 0) begin
      exp_done.push_back(1'b1);
      n = 0;
      while (!refill_done_o && n < 40) begin
        step();
        n++;
      end
      if (!refill_done_o) fail("timeout_done");
      step();
      check("busy_after_done", 64'(busy_o), 64'd0);
    end else begin
      n = 0;
      g = 0;
      while (n < 40) begin
        if (ic_repl_grant_o) g++;
        if (g == rst_beat + 1) break;
        step();
        n++;
      end
      if (g != rst_beat + 1) fail("timeout_stream");
      reset_i = 1'b1;
      step();
      reset_i = 1'b0;
      exp_words.delete();
      check("rst_grant", 64'(ic_repl_grant_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_word", 64'(rep_word_o), 64'd0);
      for (int i = 0; i < 4; i++) begin
        step();
        check("rst_no_done", {62'd0, refill_done_o, ic_repl_grant_o}, 64'd0);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_req", 64'(mem_req_o), 64'd0);
    check("reset_mem_addr", 64'(mem_addr_o), 64'd0);
    check("reset_grant", 64'(ic_repl_grant_o), 64'd0);
    check("reset_word", 64'(rep_word_o), 64'd0);
    check("reset_done", 64'(refill_done_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);
    reset_i = 1'b0;
    step();

    refill(32'h0000_1234, 2, 1'b0, 1'b0, 1'b0, '0, -1, 1'b1);
    check("basic_addr_model", 64'(32'h0000_1234 & ~32'(B - 1)), 64'h1200);
    refill(32'h0000_ABCD, 1, 1'b1, 1'b0, 1'b0, '0, -1, 1'b0);
    refill(32'h8000_0F3F, 3, 1'b0, 1'b1, 1'b0, '0, -1, 1'b0);
    refill(32'h1357_9BDF, 20, 1'b0, 1'b0, 1'b0, '0, -1, 1'b0);
    refill(32'h4000_0040, 1, 1'b0, 1'b0, 1'b1, 32'h5000_0088, -1, 1'b0);
    refill(32'h5000_0088, 0, 1'b1, 1'b0, 1'b0, '0, -1, 1'b0);
    refill(32'h2222_3333, 1, 1'b0, 1'b0, 1'b0, '0, 3, 1'b0);
    refill(32'h6666_7777, 2, 1'b1, 1'b0, 1'b0, '0, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      refill($urandom, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, '0, -1, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end

    repeat (3) step();
    check("drain_addr", 64'(exp_addr.size()), 64'd0);
    check("drain_words", 64'(exp_words.size()), 64'd0);
    check("drain_done", 64'(exp_done.size()), 64'd0);
    check("final_busy", 64'(busy_o), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout: errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
